// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM burst sequencer.
//   state_e     : sequencer FSM state encoding
//   FLD_*       : i_cfg_fld codes selecting which descriptor field a table write targets
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StGap,
    StDone
  } state_e;

  localparam logic [1:0] FLD_PERIOD = 2'd0;
  localparam logic [1:0] FLD_HIGH   = 2'd1;
  localparam logic [1:0] FLD_TIMES  = 2'd2;
  localparam logic [1:0] FLD_GAP    = 2'd3;

endpackage

// File: rtl/pwm_burst_gen.sv
// Period/repetition counter and registered PWM output for one burst.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : clear the period and repetition counters before a burst
//   run_i         : burst active this cycle (counters advance, pwm computed)
//   period_i      : cycles per PWM period
//   high_i        : high cycles at the start of each period
//   times_i       : number of periods in the burst
//   pwm_o         : registered PWM, one cycle behind the period counter
//   burst_end_o   : last cycle of the last period (combinational)
module pwm_burst_gen #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMES_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               run_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   high_i,
  input  logic [TIMES_W-1:0] times_i,
  output logic               pwm_o,
  output logic               burst_end_o
);

  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TIMES_W-1:0] tcnt_q, tcnt_d;
  logic               pwm_q, pwm_d;
  logic               pcnt_last, tcnt_last;

  assign pcnt_last   = (pcnt_q == period_i - CNT_W'(1));
  assign tcnt_last   = (tcnt_q == times_i - TIMES_W'(1));
  assign burst_end_o = run_i && pcnt_last && tcnt_last;
  assign pwm_o       = pwm_q;

  always_comb begin
    pcnt_d = pcnt_q;
    tcnt_d = tcnt_q;
    if (load_i) begin
      pcnt_d = '0;
      tcnt_d = '0;
    end else if (run_i) begin
      if (pcnt_last) begin
        pcnt_d = '0;
        tcnt_d = tcnt_q + TIMES_W'(1);
      end else begin
        pcnt_d = pcnt_q + CNT_W'(1);
      end
    end
    // high >= period keeps this true for every pcnt, high == 0 never
    pwm_d = run_i && (pcnt_q < high_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      tcnt_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tcnt_q <= tcnt_d;
      pwm_q  <= pwm_d;
    end
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM burst sequencer: plays a table of burst descriptors {period, high, times, gap}.
// Optional feature: define PWM_SEQ_LOOP_EN to restart from segment 0 when i_loop is
// high at the end of the last segment; otherwise i_loop is ignored.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cfg_*        : descriptor table write port (usable in any state)
//   i_nseg         : number of segments to play (clamped to NSEG)
//   i_start        : start pulse, honoured in idle only
//   i_abort        : abort pulse, returns to idle without o_done
//   i_loop         : loop request (PWM_SEQ_LOOP_EN builds only)
//   o_busy, o_done : sequence active, one-cycle completion pulse
//   o_seg, o_pwm   : current segment index, PWM output
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int unsigned NSEG    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMES_W = 16,
  localparam int unsigned IdxW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [IdxW-1:0]  i_cfg_idx,
  input  logic [1:0]       i_cfg_fld,
  input  logic [CNT_W-1:0] i_cfg_wdata,
  input  logic [IdxW:0]    i_nseg,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_loop,
  output logic             o_busy,
  output logic             o_done,
  output logic [IdxW-1:0]  o_seg,
  output logic             o_pwm
);

  localparam int unsigned NsegW = IdxW + 1;
  localparam logic [NsegW-1:0] NsegMax = NsegW'(NSEG);

  // Descriptor table
  logic [CNT_W-1:0]   period_tab_q [NSEG];
  logic [CNT_W-1:0]   period_tab_d [NSEG];
  logic [CNT_W-1:0]   high_tab_q   [NSEG];
  logic [CNT_W-1:0]   high_tab_d   [NSEG];
  logic [TIMES_W-1:0] times_tab_q  [NSEG];
  logic [TIMES_W-1:0] times_tab_d  [NSEG];
  logic [CNT_W-1:0]   gap_tab_q    [NSEG];
  logic [CNT_W-1:0]   gap_tab_d    [NSEG];

  // Active descriptor, only changed in StLoad
  logic [CNT_W-1:0]   act_period_q, act_period_d;
  logic [CNT_W-1:0]   act_high_q, act_high_d;
  logic [TIMES_W-1:0] act_times_q, act_times_d;
  logic [CNT_W-1:0]   act_gap_q, act_gap_d;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   seg_q, seg_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              loop_take;
  logic              burst_end;
  logic              gen_run;
  logic [NsegW-1:0]  nseg_eff;
  logic [NsegW-1:0]  seg_inc;
  state_e            step_state;
  logic [IdxW-1:0]   step_seg;

`ifdef PWM_SEQ_LOOP_EN
  assign loop_take = i_loop;
`else
  logic unused_loop;
  assign unused_loop = i_loop;
  assign loop_take   = 1'b0;
`endif

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_seg  = seg_q;

  // Abort suppresses the run so the registered PWM drops on the abort edge
  assign gen_run = (state_q == StRun) && !i_abort;

  pwm_burst_gen #(
    .CNT_W  (CNT_W),
    .TIMES_W(TIMES_W)
  ) u_burst_gen (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (state_q == StLoad),
    .run_i      (gen_run),
    .period_i   (act_period_q),
    .high_i     (act_high_q),
    .times_i    (act_times_q),
    .pwm_o      (o_pwm),
    .burst_end_o(burst_end)
  );

  // Table writes
  always_comb begin
    period_tab_d = period_tab_q;
    high_tab_d   = high_tab_q;
    times_tab_d  = times_tab_q;
    gap_tab_d    = gap_tab_q;
    if (i_cfg_we && (32'(i_cfg_idx) < NSEG)) begin
      unique case (i_cfg_fld)
        FLD_PERIOD: period_tab_d[i_cfg_idx] = i_cfg_wdata;
        FLD_HIGH:   high_tab_d[i_cfg_idx]   = i_cfg_wdata;
        FLD_TIMES:  times_tab_d[i_cfg_idx]  = i_cfg_wdata[TIMES_W-1:0];
        FLD_GAP:    gap_tab_d[i_cfg_idx]    = i_cfg_wdata;
      endcase
    end
  end

  // Where to go once the current segment (burst plus gap) is finished
  always_comb begin
    nseg_eff   = (i_nseg > NsegMax) ? NsegMax : i_nseg;
    seg_inc    = {1'b0, seg_q} + NsegW'(1);
    step_state = StDone;
    step_seg   = seg_q;
    if (seg_inc < nseg_eff) begin
      step_state = StLoad;
      step_seg   = seg_inc[IdxW-1:0];
    end else if (loop_take) begin
      step_state = StLoad;
      step_seg   = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    gcnt_d       = gcnt_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    act_times_d  = act_times_q;
    act_gap_d    = act_gap_q;

    case (state_q)
      StIdle: begin
        seg_d = '0;
        if (i_start && !i_abort) begin
          state_d = (nseg_eff == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        act_period_d = period_tab_q[seg_q];
        act_high_d   = high_tab_q[seg_q];
        act_times_d  = times_tab_q[seg_q];
        act_gap_d    = gap_tab_q[seg_q];
        // Empty burst: decide from the table entry being loaded this cycle
        if ((period_tab_q[seg_q] == '0) || (times_tab_q[seg_q] == '0)) begin
          if (gap_tab_q[seg_q] != '0) begin
            state_d = StGap;
            gcnt_d  = '0;
          end else begin
            state_d = step_state;
            seg_d   = step_seg;
          end
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (burst_end) begin
          if (act_gap_q != '0) begin
            state_d = StGap;
            gcnt_d  = '0;
          end else begin
            state_d = step_state;
            seg_d   = step_seg;
          end
        end
      end
      StGap: begin
        if (gcnt_q == act_gap_q - CNT_W'(1)) begin
          state_d = step_state;
          seg_d   = step_seg;
        end else begin
          gcnt_d = gcnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        seg_d   = '0;
      end
      default: begin
        state_d = StIdle;
        seg_d   = '0;
      end
    endcase

    // Abort wins over any end-of-burst or end-of-gap transition
    if (i_abort && (state_q != StIdle)) begin
      state_d = StIdle;
      seg_d   = '0;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      seg_q        <= '0;
      gcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_period_q <= '0;
      act_high_q   <= '0;
      act_times_q  <= '0;
      act_gap_q    <= '0;
      for (int unsigned i = 0; i < NSEG; i++) begin
        period_tab_q[i] <= '0;
        high_tab_q[i]   <= '0;
        times_tab_q[i]  <= '0;
        gap_tab_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      gcnt_q       <= gcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      act_times_q  <= act_times_d;
      act_gap_q    <= act_gap_d;
      period_tab_q <= period_tab_d;
      high_tab_q   <= high_tab_d;
      times_tab_q  <= times_tab_d;
      gap_tab_q    <= gap_tab_d;
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: directed vector table, hand-written corner
// sequences (abort, reset, mid-run rewrite, loop) and randomized descriptor tables
// checked against a cycle-list reference model.
module tb_pwm_seq_ctrl;
  import pwm_seq_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_idx;
  logic [1:0]  i_cfg_fld;
  logic [31:0] i_cfg_wdata;
  logic [2:0]  i_nseg;
  logic        i_start;
  logic        i_abort;
  logic        i_loop;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_seg;
  logic        o_pwm;

  pwm_seq_ctrl #(
    .NSEG   (4),
    .CNT_W  (32),
    .TIMES_W(16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_idx  (i_cfg_idx),
    .i_cfg_fld  (i_cfg_fld),
    .i_cfg_wdata(i_cfg_wdata),
    .i_nseg     (i_nseg),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_loop     (i_loop),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_seg      (o_seg),
    .o_pwm      (o_pwm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec;
  int n_err;

  // Each entry word is {period, high, times, gap}, one byte per field
  typedef struct packed {
    logic [3:0][31:0] ent;
    logic [2:0]       nseg;
    logic [63:0]      mask;     // bit c = expected o_pwm in cycle c after start
    logic [7:0]       done_cyc;
    logic [7:0]       fseg;     // expected o_seg in the done cycle
  } vec_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] seg;
    logic       src;  // PWM level this cycle produces (seen on o_pwm next cycle)
  } exp_t;

  vec_t vecs[7];
  exp_t expq[$];
  int   tb_tab[4][4];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [1:0] fld, input logic [31:0] data);
    i_cfg_we    = 1'b1;
    i_cfg_idx   = idx;
    i_cfg_fld   = fld;
    i_cfg_wdata = data;
    step();
    i_cfg_we    = 1'b0;
    tb_tab[idx][fld] = int'(data);
  endtask

  task automatic wr_entry(input int e, input logic [31:0] w);
    wr(2'(e), FLD_PERIOD, {24'd0, w[31:24]});
    wr(2'(e), FLD_HIGH,   {24'd0, w[23:16]});
    wr(2'(e), FLD_TIMES,  {24'd0, w[15:8]});
    wr(2'(e), FLD_GAP,    {24'd0, w[7:0]});
  endtask

  // Start a sequence and check every cycle up to one past the done pulse
  task automatic play(input string nm, input logic [63:0] mask, input int done_cyc,
                      input int fseg, input int wcyc, input logic [1:0] widx,
                      input logic [1:0] wfld, input logic [31:0] wdata, input int loop_off);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c <= done_cyc + 1; c++) begin
      chk({nm, ".pwm"}, c, 32'(o_pwm), 32'(mask[c]));
      chk({nm, ".done"}, c, 32'(o_done), 32'(c == done_cyc));
      chk({nm, ".busy"}, c, 32'(o_busy), 32'(c <= done_cyc));
      if (c == done_cyc) chk({nm, ".seg"}, c, 32'(o_seg), 32'(fseg));
      if (c == wcyc) begin
        i_cfg_we    = 1'b1;
        i_cfg_idx   = widx;
        i_cfg_fld   = wfld;
        i_cfg_wdata = wdata;
        tb_tab[widx][wfld] = int'(wdata);
      end
      if (c == loop_off) i_loop = 1'b0;
      step();
      i_cfg_we = 1'b0;
    end
  endtask

  // Reference model: list the cycles a sequence spends, segment by segment
  task automatic build_model(input int nseg);
    int n, p, h, t, g;
    expq.delete();
    n = (nseg > 4) ? 4 : nseg;
    if (n == 0) begin
      expq.push_back('{busy: 1'b1, done: 1'b1, seg: 2'd0, src: 1'b0});
    end else begin
      for (int s = 0; s < n; s++) begin
        p = tb_tab[s][0];
        h = tb_tab[s][1];
        t = tb_tab[s][2];
        g = tb_tab[s][3];
        expq.push_back('{busy: 1'b1, done: 1'b0, seg: 2'(s), src: 1'b0});
        if (p != 0 && t != 0)
          for (int k = 0; k < p * t; k++)
            expq.push_back('{busy: 1'b1, done: 1'b0, seg: 2'(s), src: ((k % p) < h)});
        for (int k = 0; k < g; k++)
          expq.push_back('{busy: 1'b1, done: 1'b0, seg: 2'(s), src: 1'b0});
      end
      expq.push_back('{busy: 1'b1, done: 1'b1, seg: 2'(n - 1), src: 1'b0});
    end
    expq.push_back('{busy: 1'b0, done: 1'b0, seg: 2'd0, src: 1'b0});
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    i_rst_n     = 1'b1;
    i_cfg_we    = 1'b0;
    i_cfg_idx   = '0;
    i_cfg_fld   = '0;
    i_cfg_wdata = '0;
    i_nseg      = '0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_loop      = 1'b0;
    for (int e = 0; e < 4; e++)
      for (int f = 0; f < 4; f++) tb_tab[e][f] = 0;

    vecs[0] = '{ent: {32'h0, 32'h0, 32'h0, 32'h05020300}, nseg: 3'd1,
                mask: 64'h318C, done_cyc: 8'd16, fseg: 8'd0};
    vecs[1] = '{ent: {32'h0, 32'h0, 32'h03030100, 32'h04010203}, nseg: 3'd2,
                mask: 64'h1C044, done_cyc: 8'd16, fseg: 8'd1};
    vecs[2] = '{ent: {32'h0, 32'h0, 32'h02010100, 32'h05020000}, nseg: 3'd2,
                mask: 64'h8, done_cyc: 8'd4, fseg: 8'd1};
    vecs[3] = '{ent: {32'h0, 32'h0, 32'h0, 32'h05020300}, nseg: 3'd0,
                mask: 64'h0, done_cyc: 8'd0, fseg: 8'd0};
    vecs[4] = '{ent: {32'h0, 32'h0, 32'h0, 32'h03050200}, nseg: 3'd1,
                mask: 64'hFC, done_cyc: 8'd7, fseg: 8'd0};
    vecs[5] = '{ent: {32'h0, 32'h0, 32'h0, 32'h03000201}, nseg: 3'd1,
                mask: 64'h0, done_cyc: 8'd8, fseg: 8'd0};
    vecs[6] = '{ent: {32'h02010100, 32'h00000002, 32'h0, 32'h01010100}, nseg: 3'd7,
                mask: 64'h104, done_cyc: 8'd9, fseg: 8'd3};

    // Reset
    #1 i_rst_n = 1'b0;
    #10;
    chk("rst.busy", 0, 32'(o_busy), 32'd0);
    chk("rst.done", 0, 32'(o_done), 32'd0);
    chk("rst.seg", 0, 32'(o_seg), 32'd0);
    chk("rst.pwm", 0, 32'(o_pwm), 32'd0);
    #2 i_rst_n = 1'b1;
    step();

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      for (int e = 0; e < 4; e++) wr_entry(e, vecs[v].ent[e]);
      i_nseg = vecs[v].nseg;
      play($sformatf("vec%0d", v), vecs[v].mask, int'(vecs[v].done_cyc),
           int'(vecs[v].fseg), -1, 2'd0, 2'd0, 32'd0, -1);
    end

    // Rewrite high during the burst: current burst keeps high=2, next uses high=1
    for (int e = 0; e < 4; e++) wr_entry(e, vecs[0].ent[e]);
    i_nseg = 3'd1;
    play("rewrite", 64'h318C, 16, 0, 4, 2'd0, FLD_HIGH, 32'd1, -1);
    play("after_rewrite", 64'h1084, 16, 0, -1, 2'd0, 2'd0, 32'd0, -1);

    // Abort while playing segment 1, with i_start also high
    for (int e = 0; e < 4; e++) wr_entry(e, vecs[1].ent[e]);
    i_nseg  = 3'd2;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (14) step();
    chk("abort.pre_pwm", 14, 32'(o_pwm), 32'd1);
    chk("abort.pre_seg", 14, 32'(o_seg), 32'd1);
    i_abort = 1'b1;
    i_start = 1'b1;
    step();
    chk("abort.busy", 15, 32'(o_busy), 32'd0);
    chk("abort.pwm", 15, 32'(o_pwm), 32'd0);
    chk("abort.seg", 15, 32'(o_seg), 32'd0);
    chk("abort.done", 15, 32'(o_done), 32'd0);
    step();
    chk("abort_start_idle.busy", 16, 32'(o_busy), 32'd0);
    i_abort = 1'b0;
    i_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("abort_after.done", c, 32'(o_done), 32'd0);
      chk("abort_after.busy", c, 32'(o_busy), 32'd0);
    end

    // Abort on the very cycle the burst ends
    for (int e = 0; e < 4; e++) wr_entry(e, vecs[0].ent[e]);
    i_nseg  = 3'd1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (15) step();
    chk("abort_end.pre_busy", 15, 32'(o_busy), 32'd1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_end.done", 16, 32'(o_done), 32'd0);
    chk("abort_end.busy", 16, 32'(o_busy), 32'd0);
    chk("abort_end.pwm", 16, 32'(o_pwm), 32'd0);
    step();
    chk("abort_end.done2", 17, 32'(o_done), 32'd0);

    // Asynchronous reset mid-burst clears outputs and the table
    for (int e = 0; e < 4; e++) wr_entry(e, vecs[1].ent[e]);
    i_nseg  = 3'd2;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (14) step();
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst.busy", 0, 32'(o_busy), 32'd0);
    chk("async_rst.pwm", 0, 32'(o_pwm), 32'd0);
    chk("async_rst.seg", 0, 32'(o_seg), 32'd0);
    chk("async_rst.done", 0, 32'(o_done), 32'd0);
    #1 i_rst_n = 1'b1;
    for (int e = 0; e < 4; e++)
      for (int f = 0; f < 4; f++) tb_tab[e][f] = 0;
    step();
    i_nseg = 3'd1;
    play("zero_table", 64'h0, 1, 0, -1, 2'd0, 2'd0, 32'd0, -1);

    // Loop request
    wr_entry(0, 32'h03010100);
    i_nseg = 3'd1;
    i_loop = 1'b1;
`ifdef PWM_SEQ_LOOP_EN
    play("loop", 64'h444, 12, 0, -1, 2'd0, 2'd0, 32'd0, 8);
`else
    play("noloop", 64'h4, 4, 0, -1, 2'd0, 2'd0, 32'd0, -1);
`endif
    i_loop = 1'b0;

    // Randomized descriptor tables against the reference model
    for (int it = 0; it < 40; it++) begin
      for (int e = 0; e < 4; e++) begin
        logic [7:0] p, h, t, g;
        p = 8'($urandom_range(0, 5));
        h = 8'($urandom_range(0, 6));
        t = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        g = 8'($urandom_range(0, 3));
        wr_entry(e, {p, h, t, g});
      end
      i_nseg = 3'($urandom_range(0, 7));
`ifndef PWM_SEQ_LOOP_EN
      i_loop = 1'($urandom_range(0, 1));
`endif
      build_model(int'(i_nseg));
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 0; c < expq.size(); c++) begin
        chk($sformatf("rnd%0d.busy", it), c, 32'(o_busy), 32'(expq[c].busy));
        chk($sformatf("rnd%0d.done", it), c, 32'(o_done), 32'(expq[c].done));
        chk($sformatf("rnd%0d.seg", it), c, 32'(o_seg), 32'(expq[c].seg));
        chk($sformatf("rnd%0d.pwm", it), c, 32'(o_pwm),
            (c == 0) ? 32'd0 : 32'(expq[c - 1].src));
        step();
      end
      i_loop = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter NSEG, default 4, meaning number of burst-descriptor table entries.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the period, high and gap counter width in clock cycles.
REQ-003 SHALL have parameter TIMES_W, default 16, meaning the repetition count width.
REQ-004 SHALL have ports:
 - i_clk  in  1  single 50 MHz clock.
 - i_rst_n  in  1  asynchronous active-low reset.
 - i_cfg_we  in  1  table write strobe.
 - i_cfg_idx  in  clog2(NSEG)  entry index.
 - i_cfg_fld  in  2  field select: 0 period, 1 high, 2 times, 3 gap.
 - i_cfg_wdata  in  CNT_W  write data; times uses the low TIMES_W bits.
 - i_nseg  in  clog2(NSEG)+1  number of segments to play.
 - i_start  in  1  start pulse.
 - i_abort  in  1  abort pulse.
 - i_loop  in  1  loop request.
 - o_busy  out  1  sequence active.
 - o_done  out  1  one-cycle completion pulse.
 - o_seg  out  clog2(NSEG)  current segment index.
 - o_pwm  out  1  PWM output.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RUN, GAP, DONE.
REQ-006 SHALL leave IDLE for LOAD on the cycle after i_start=1, with o_seg=0.
REQ-007 SHALL ignore i_start outside IDLE.
REQ-008 SHALL, in LOAD (exactly one cycle), copy table entry o_seg into active period/high/times/gap registers, then enter RUN.
REQ-009 SHALL skip RUN when active period==0 or times==0; it goes directly to GAP, or to the next step if gap==0.
REQ-010 SHALL, in RUN, count pcnt 0..period-1 and wrap; it counts tcnt once per wrap; RUN ends on the cycle pcnt==period-1 and tcnt==times-1.
REQ-011 SHALL register o_pwm = (state==RUN && pcnt<high), so o_pwm lags pcnt by one cycle.
REQ-012 SHALL make o_pwm constant high for the whole burst when high>=period, and constant low when high==0.
REQ-013 SHALL hold o_pwm low in GAP for exactly gap cycles; gap==0 means no GAP state.
REQ-014 SHALL define the next step after a segment as LOAD of o_seg+1 if o_seg+1<i_nseg, otherwise DONE.
REQ-015 SHALL assert o_done for one cycle in DONE, then return to IDLE.
REQ-016 SHALL treat i_nseg==0 as start -> DONE directly, with no LOAD and no PWM output.
REQ-017 SHALL treat i_nseg>NSEG as NSEG.
REQ-018 SHALL assert o_busy in every state except IDLE.
REQ-019 SHALL accept table writes in every state; a write takes effect at the next LOAD of that entry, and active registers are never altered mid-segment.
REQ-020 SHALL, on i_abort=1 in any non-IDLE state, go to IDLE on the next edge, force o_pwm=0 and o_seg=0, and give no o_done pulse.
REQ-021 SHALL give i_abort priority over the RUN/GAP end condition when both fall on the same cycle.
REQ-022 SHALL ignore i_abort in IDLE; if i_abort and i_start are both 1 in IDLE, it stays IDLE.

Reset
REQ-023 SHALL on i_rst_n=0 asynchronously force state IDLE, o_pwm=0, o_busy=0, o_done=0, o_seg=0, all counters 0, and all table entries 0.

Configuration
REQ-024 SHALL, with macro PWM_SEQ_LOOP_EN defined, go from the last segment's end to LOAD of segment 0 when i_loop=1 (sampled at that end), with no DONE and no o_done pulse.
REQ-025 SHALL, without PWM_SEQ_LOOP_EN, keep port i_loop but ignore it and always take DONE.

Structure
REQ-026 SHALL place the FSM state enum and the field-select constants (FLD_PERIOD=0, FLD_HIGH=1, FLD_TIMES=2, FLD_GAP=3) in shared package pwm_seq_pkg.
REQ-027 SHALL implement the period/repetition counting and o_pwm register as sub-module pwm_burst_gen (load, run, period, high, times -> pwm, burst_end); the FSM, table and gap counter stay in pwm_seq_ctrl.

Verification
REQ-028 SHALL cover: entry0 = {period 5, high 2, times 3, gap 0}, nseg=1, start -> o_pwm pattern 11000 x3, o_busy high, o_done one cycle after the last period, o_busy low the next cycle.
REQ-029 SHALL cover: entries 0 {4,1,2,gap 3} and 1 {3,3,1,0}, nseg=2 -> 1000 1000, 3 low cycles, o_seg 0->1, 111, one o_done.
REQ-030 SHALL cover: entry0 times=0, entry1 {2,1,1,0}, nseg=2 -> no pulses for seg0, then 10, o_done.
REQ-031 SHALL cover: abort in cycle 3 of RUN -> o_pwm=0 and o_busy=0 next cycle, no o_done; i_start also asserted with the abort -> stays IDLE.
REQ-032 SHALL cover: rewrite entry0 high=1 during RUN of seg0 -> current burst unchanged; next start uses high=1.
REQ-033 SHALL cover: with PWM_SEQ_LOOP_EN and i_loop=1, nseg=1 {3,1,1,0} -> 100100100... with no o_done until i_loop=0, then one o_done; without the macro -> single 100 then o_done.
